// File: rtl/foc_fixed_pkg.sv
// Shared fixed-point types, limits clamp and PI sequencer states
// for the FOC current-loop regulators.
package foc_fixed_pkg;

    localparam int PI_N = 10;
    localparam int PI_F = 9;

    typedef logic signed [PI_N-1:0] word_t;
    typedef logic signed [PI_N+2:0] acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_P,
        S_MUL_I,
        S_SUM,
        S_OUT
    } pi_state_e;

    // Upper limit wins when the limits are inverted.
    function automatic acc_t clamp(
        input acc_t x,
        input acc_t hi,
        input acc_t lo
    );
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/fixed_mul.sv
// Registered signed N x N multiply, arithmetic shift right by F,
// kept in N+1 bits (floor rounding).
module fixed_mul
    import foc_fixed_pkg::*;
#(
    parameter int N = PI_N,
    parameter int F = PI_F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N:0]   p_o
);

    logic signed [2*N-1:0] prod;
    logic signed [N:0]     p_q;

    assign prod = a_i * b_i;
    assign p_o  = p_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= (N+1)'(prod >>> F);
        end
    end

endmodule

// File: rtl/pi_antiwindup.sv
// Sequential PI regulator with output limits and anti-windup.
// Define PI_BACKCALC_EN for back-calculation instead of conditional integration.
module pi_antiwindup
    import foc_fixed_pkg::*;
#(
    parameter int N = PI_N,
    parameter int F = PI_F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] setpoint,
    input  logic signed [N-1:0] feedback,
    input  logic signed [N-1:0] kp,
    input  logic signed [N-1:0] ki,
    input  logic signed [N-1:0] out_max,
    input  logic signed [N-1:0] out_min,
    input  logic                integ_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] y,
    output logic signed [N-1:0] integ
);

    pi_state_e          state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic signed [N-1:0] kp_q;
    logic signed [N-1:0] ki_q;
    logic signed [N-1:0] max_q;
    logic signed [N-1:0] min_q;
    logic signed [N-1:0] err_q;
    logic signed [N:0]   p_q;
    logic signed [N-1:0] y_q;
    logic signed [N-1:0] integ_q;

    logic signed [N:0]   err_wide;
    logic signed [N-1:0] err_d;
    logic signed [N-1:0] mul_a;
    logic signed [N:0]   mul_p;
    acc_t                p_w;
    acc_t                i_w;
    acc_t                inc_w;
    acc_t                hi_w;
    acc_t                lo_w;
    acc_t                u_try;
    acc_t                integ_w;
    acc_t                y_w;
    logic signed [N-1:0] integ_d;
    logic signed [N-1:0] y_d;
    logic                accept;

    assign accept    = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign integ     = integ_q;

    // Saturate the N+1-bit difference when its top two bits disagree.
    always_comb begin
        err_wide = {setpoint[N-1], setpoint} - {feedback[N-1], feedback};
        err_d    = err_wide[N-1:0];
        if (err_wide[N] != err_wide[N-1]) begin
            err_d = err_wide[N] ? {1'b1, {(N-1){1'b0}}}
                                : {1'b0, {(N-1){1'b1}}};
        end
    end

    assign mul_a = (state_q == S_MUL_P) ? kp_q : ki_q;

    fixed_mul #(
        .N (N),
        .F (F)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (mul_a),
        .b_i   (err_q),
        .p_o   (mul_p)
    );

    // In SUM the multiplier register holds inc, p_q holds p.
    always_comb begin
        p_w   = {{2{p_q[N]}}, p_q};
        inc_w = {{2{mul_p[N]}}, mul_p};
        i_w   = {{3{integ_q[N-1]}}, integ_q};
        hi_w  = {{3{max_q[N-1]}}, max_q};
        lo_w  = {{3{min_q[N-1]}}, min_q};
        u_try = p_w + i_w + inc_w;
`ifdef PI_BACKCALC_EN
        integ_w = clamp(i_w + inc_w - (u_try - clamp(u_try, hi_w, lo_w)),
                        hi_w, lo_w);
`else
        if ((u_try > hi_w && err_q > 0) || (u_try < lo_w && err_q < 0)) begin
            integ_w = i_w;
        end else begin
            integ_w = clamp(i_w + inc_w, hi_w, lo_w);
        end
`endif
        y_w     = clamp(p_w + integ_w, hi_w, lo_w);
        integ_d = N'(integ_w);
        y_d     = N'(y_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            kp_q        <= '0;
            ki_q        <= '0;
            max_q       <= '0;
            min_q       <= '0;
            err_q       <= '0;
            p_q         <= '0;
            y_q         <= '0;
            integ_q     <= '0;
        end else begin
            if (integ_clr) begin
                integ_q <= '0;
            end else if (state_q == S_SUM) begin
                integ_q <= integ_d;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        kp_q       <= kp;
                        ki_q       <= ki;
                        max_q      <= out_max;
                        min_q      <= out_min;
                        err_q      <= err_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MUL_P;
                    end
                end
                S_MUL_P: begin
                    state_q <= S_MUL_I;
                end
                S_MUL_I: begin
                    p_q     <= mul_p;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    y_q         <= y_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pi_antiwindup.sv
// Directed self-checking bench for pi_antiwindup (N=10, F=9).
module tb_pi_antiwindup;

`ifdef PI_BACKCALC_EN
    localparam int WIND_I = -10;
`else
    localparam int WIND_I = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [9:0] setpoint = '0;
    logic signed [9:0] feedback = '0;
    logic signed [9:0] kp = '0;
    logic signed [9:0] ki = '0;
    logic signed [9:0] out_max = '0;
    logic signed [9:0] out_min = '0;
    logic              integ_clr = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [9:0] y;
    logic signed [9:0] integ;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pi_antiwindup #(.N(10), .F(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .setpoint  (setpoint),
        .feedback  (feedback),
        .kp        (kp),
        .ki        (ki),
        .out_max   (out_max),
        .out_min   (out_min),
        .integ_clr (integ_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .integ     (integ)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic run(input int sp, input int fb, input bit clr,
                       input int hold, input int ey, input int ei,
                       input string tag);
        @(negedge clk);
        chk({tag, "_rdy"}, int'(in_ready), 1);
        setpoint = 10'(sp);
        feedback = 10'(fb);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_acc"}, int'(in_ready), 0);
        @(posedge clk);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, int'(out_valid), 0);
        integ_clr = clr;
        @(posedge clk); #1;
        integ_clr = 1'b0;
        chk({tag, "_lat3"}, int'(out_valid), 1);
        chk({tag, "_y"}, int'(y), ey);
        chk({tag, "_integ"}, int'(integ), ei);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            setpoint = -10'sd300;
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, int'(out_valid), 1);
            chk({tag, "_hold_y"}, int'(y), ey);
            chk({tag, "_hold_rdy"}, int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, int'(out_valid), 0);
        chk({tag, "_ret"}, int'(in_ready), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", int'(in_ready), 1);
        chk("rst_v", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_integ", int'(integ), 0);
        @(negedge clk);
        rst_n = 1'b1;

        kp = 10'sd256;
        ki = 10'sd64;
        out_max = 10'sd511;
        out_min = -10'sd511;
        run(200, 0, 1'b0, 0, 125, 25, "basic1");
        run(200, 0, 1'b0, 0, 150, 50, "basic2");
        run(200, 0, 1'b1, 0, 175, 0, "clr_sum");

        out_max = 10'sd90;
        run(200, 0, 1'b0, 0, 90, WIND_I, "wind1");
        run(200, 0, 1'b0, 0, 90, WIND_I, "wind2");
        run(200, 0, 1'b0, 0, 90, WIND_I, "wind3");

        @(negedge clk);
        integ_clr = 1'b1;
        @(posedge clk); #1;
        integ_clr = 1'b0;
        chk("clr_idle_integ", int'(integ), 0);
        chk("clr_idle_y", int'(y), 90);

        out_max = 10'sd511;
        kp = 10'sd511;
        run(-512, 511, 1'b0, 0, -511, 0, "sat");

        kp = 10'sd256;
        run(200, 0, 1'b0, 6, 125, 25, "bp");
        run(200, 0, 1'b0, 0, 150, 50, "after_bp");

        @(negedge clk);
        setpoint = 10'sd200;
        feedback = 10'sd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_v", int'(out_valid), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_integ", int'(integ), 0);
        chk("abort_rdy", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(200, 0, 1'b0, 0, 125, 25, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
